// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared widths, limits, FSM encoding and saturate/round helpers
// Contents: DIN_W/ACC_W/CNT_W/OUT_W widths, ACC and INT8 limits, state_t,
//           sat_signed (clamp to [lo,hi]), round_shift (round half up, arithmetic shift)
package cnn_pkg;

  localparam int DIN_W = 18;
  localparam int ACC_W = 32;
  localparam int CNT_W = 12;
  localparam int OUT_W = 8;

  // Limits held one bit wider than the accumulator so sums can be checked before clamping
  localparam logic signed [ACC_W:0] ACC_MIN  = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] ACC_MAX  = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] INT8_MIN = (ACC_W+1)'(-128);
  localparam logic signed [ACC_W:0] INT8_MAX = (ACC_W+1)'(127);
  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  function automatic logic signed [ACC_W:0] sat_signed(
    input logic signed [ACC_W:0] x,
    input logic signed [ACC_W:0] lo,
    input logic signed [ACC_W:0] hi
  );
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  // The rounding bump is at most 2^30 and r at most 2^31-1, so ACC_W+1 bits never overflow
  function automatic logic signed [ACC_W:0] round_shift(
    input logic signed [ACC_W-1:0] r,
    input logic [4:0]              sh
  );
    logic signed [ACC_W:0] rx;
    logic signed [ACC_W:0] bump;
    rx = {r[ACC_W-1], r};
    if (sh == 5'd0) return rx;
    bump = (ACC_W+1)'(1) << (sh - 5'd1);
    return (rx + bump) >>> sh;
  endfunction

endpackage

// File: rtl/cal_psum_accum_requant_if.sv
// rtl/cal_psum_accum_requant_if.sv - stream bundle between adder tree, accumulator and writeback
// Inputs to the block: din, din_valid, first, last, bias, shift, relu_en
// Outputs of the block: dout, dout_valid, ch_count, proto_err, sat_flag
interface cal_psum_accum_requant_if;
  import cnn_pkg::*;

  logic signed [DIN_W-1:0] din;
  logic                    din_valid;
  logic                    first;
  logic                    last;
  logic signed [ACC_W-1:0] bias;
  logic [4:0]              shift;
  logic                    relu_en;
  logic signed [OUT_W-1:0] dout;
  logic                    dout_valid;
  logic [CNT_W-1:0]        ch_count;
  logic                    proto_err;
  logic                    sat_flag;

  modport master (
    output din, din_valid, first, last, bias, shift, relu_en,
    input  dout, dout_valid, ch_count, proto_err, sat_flag
  );

  modport slave (
    input  din, din_valid, first, last, bias, shift, relu_en,
    output dout, dout_valid, ch_count, proto_err, sat_flag
  );

endinterface

// File: rtl/cal_requant_int8.sv
// rtl/cal_requant_int8.sv - bias add, ReLU, rounded shift and INT8 saturation (two stages)
// Ports: clk, rst (sync, active-high); in_valid/sum/bias/shift/relu_en/cnt from the
//        accumulator; dout/dout_valid/ch_count result; sat one-cycle saturation pulse
module cal_requant_int8
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [ACC_W-1:0] sum,
  input  logic signed [ACC_W-1:0] bias,
  input  logic [4:0]              shift,
  input  logic                    relu_en,
  input  logic [CNT_W-1:0]        cnt,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid,
  output logic [CNT_W-1:0]        ch_count,
  output logic                    sat
);

  logic signed [ACC_W:0]   s_w, s_sat, q, q_sat;
  logic signed [ACC_W-1:0] r;
  logic                    s_ovf, clip;

  logic                    v1;
  logic signed [ACC_W-1:0] r1;
  logic [4:0]              sh1;
  logic [CNT_W-1:0]        cnt1;

  always_comb begin
    s_w   = {sum[ACC_W-1], sum} + {bias[ACC_W-1], bias};
    s_sat = sat_signed(s_w, ACC_MIN, ACC_MAX);
    s_ovf = (s_sat != s_w);
    r     = (relu_en && s_sat[ACC_W]) ? '0 : s_sat[ACC_W-1:0];
    q     = round_shift(r1, sh1);
    q_sat = sat_signed(q, INT8_MIN, INT8_MAX);
    clip  = (q_sat != q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      r1         <= '0;
      sh1        <= '0;
      cnt1       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ch_count   <= '0;
      sat        <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        r1   <= r;
        sh1  <= shift;
        cnt1 <= cnt;
      end
      dout_valid <= v1;
      // Result registers hold between groups
      if (v1) begin
        dout     <= q_sat[OUT_W-1:0];
        ch_count <= cnt1;
      end
      sat <= (in_valid && s_ovf) || (v1 && clip);
    end
  end

endmodule

// File: rtl/cal_psum_accum_requant.sv
// rtl/cal_psum_accum_requant.sv - cross-channel partial-sum accumulator with INT8 requantization
// Ports: clk, rst (sync, active-high); bus (slave): din/din_valid/first/last/bias/shift/relu_en
//        in, dout/dout_valid/ch_count/proto_err/sat_flag out
module cal_psum_accum_requant
  import cnn_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  cal_psum_accum_requant_if.slave   bus
);

  state_t                  state, state_next;
  logic signed [ACC_W-1:0] acc, acc_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic signed [ACC_W:0]   sum_w, acc_sat;
  logic                    open_new, proto_hit, ovf, cnt_sat;
  logic                    proto_q, sat_q, rq_sat;

  logic                    s0_valid;
  logic signed [ACC_W-1:0] s0_sum, s0_bias;
  logic [4:0]              s0_shift;
  logic                    s0_relu;
  logic [CNT_W-1:0]        s0_cnt;

  // A beat without first while IDLE still opens a group; first inside ACC restarts it
  always_comb begin
    state_next = state;
    open_new   = 1'b0;
    proto_hit  = 1'b0;
    if (bus.din_valid) begin
      case (state)
        IDLE: begin
          open_new   = 1'b1;
          proto_hit  = !bus.first;
          state_next = bus.last ? IDLE : ACC;
        end
        ACC: begin
          open_new   = bus.first;
          proto_hit  = bus.first;
          state_next = bus.last ? IDLE : ACC;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    sum_w    = (open_new ? {(ACC_W+1){1'b0}} : {acc[ACC_W-1], acc})
             + {{(ACC_W+1-DIN_W){bus.din[DIN_W-1]}}, bus.din};
    acc_sat  = sat_signed(sum_w, ACC_MIN, ACC_MAX);
    ovf      = (acc_sat != sum_w);
    acc_next = acc_sat[ACC_W-1:0];
    cnt_sat  = !open_new && (cnt == CNT_MAX);
    cnt_next = open_new ? CNT_W'(1) : (cnt_sat ? cnt : cnt + CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      proto_q  <= 1'b0;
      sat_q    <= 1'b0;
      s0_valid <= 1'b0;
      s0_sum   <= '0;
      s0_bias  <= '0;
      s0_shift <= '0;
      s0_relu  <= 1'b0;
      s0_cnt   <= '0;
    end else begin
      state    <= state_next;
      s0_valid <= bus.din_valid && bus.last;
      if (bus.din_valid) begin
        acc <= acc_next;
        cnt <= cnt_next;
        if (proto_hit || cnt_sat) proto_q <= 1'b1;
        if (bus.last) begin
          s0_sum   <= acc_next;
          s0_bias  <= bus.bias;
          s0_shift <= bus.shift;
          s0_relu  <= bus.relu_en;
          s0_cnt   <= cnt_next;
        end
      end
      if ((bus.din_valid && ovf) || rq_sat) sat_q <= 1'b1;
    end
  end

  cal_requant_int8 u_requant (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (s0_valid),
    .sum        (s0_sum),
    .bias       (s0_bias),
    .shift      (s0_shift),
    .relu_en    (s0_relu),
    .cnt        (s0_cnt),
    .dout       (bus.dout),
    .dout_valid (bus.dout_valid),
    .ch_count   (bus.ch_count),
    .sat        (rq_sat)
  );

  assign bus.proto_err = proto_q;
  assign bus.sat_flag  = sat_q;

endmodule
